// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM state
// encodings, stall vector patterns, stop/no-stop levels and reset level.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    // Stall vector bit order: [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;

    // This block's reset is active-low
    localparam logic RstEnable = 1'b0;

    localparam logic [3:0] SEL_WORD = 4'b1111;

    // Highest-stage stall cause wins: a stalled later stage freezes all earlier ones
    function automatic logic [5:0] stall_vec(
        input logic mem_hold,
        input logic ex_req,
        input logic id_req,
        input logic if_hold
    );
        logic [5:0] v;
        if (mem_hold) begin
            v = STALL_MEM;
        end else if (ex_req) begin
            v = STALL_EX;
        end else if (id_req) begin
            v = STALL_ID;
        end else if (if_hold) begin
            v = STALL_IF;
        end else begin
            v = STALL_NONE;
        end
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Watchdog for hung RAM transactions: counts wait cycles without an
// acknowledge and flags expiry in the cycle the limit is reached, so the
// controller can complete the transaction in that same cycle.
module pipe_ctrl_wdog
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_wait,
    input  logic i_ack,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    generate
        if (TIMEOUT > 0) begin : g_wdog
            logic [CNT_W-1:0] r_cnt;
            logic             w_hit;

            // The current wait cycle is the TIMEOUT-th one without an ack
            assign w_hit    = (r_cnt == CNT_W'(TIMEOUT - 1));
            assign o_expire = i_wait & ~i_ack & w_hit;

            // Count unacknowledged wait cycles; clear on ack, expiry or idle
            always_ff @(posedge clk or negedge rst_n) begin
                if (rst_n == RstEnable) begin
                    r_cnt <= '0;
                end else if (i_wait && !i_ack && !w_hit) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else begin
                    r_cnt <= '0;
                end
            end
        end else begin : g_off
            assign o_expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall vector generation, branch flush,
// and arbitration of the single shared RAM port between fetch and data
// access, with wrong-path fetch discard and a hung-transaction watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              branch_flag_i,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              ram_req,
    output logic              ram_we,
    output logic [3:0]        ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ack,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [5:0]        stall,
    output logic              flush,
    output logic              err_o
);

    state_e            r_state;
    logic              r_ram_req;
    logic              r_ram_we;
    logic [3:0]        r_ram_sel;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_drop;

    logic              w_if_wait;
    logic              w_mem_wait;
    logic              w_wait;
    logic              w_expire;
    logic              w_done;
    logic [DATA_W-1:0] w_rdata;

    assign w_if_wait  = (r_state == ST_IF_WAIT);
    assign w_mem_wait = (r_state == ST_MEM_WAIT);
    assign w_wait     = w_if_wait | w_mem_wait;

    pipe_ctrl_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst),
        .i_wait   (w_wait),
        .i_ack    (ram_ack),
        .o_expire (w_expire)
    );

    // A transaction ends on a real ack or on forced watchdog completion
    assign w_done  = ram_ack | w_expire;
    // Forced completion returns zero data instead of whatever is on the bus
    assign w_rdata = w_expire ? '0 : ram_rdata;

    assign mem_ack   = w_mem_wait & w_done;
    assign mem_rdata = w_rdata;
    assign if_ack    = w_if_wait & w_done & ~r_drop;
    assign if_rdata  = w_rdata;
    assign err_o     = w_expire;

    assign stall = stall_vec(mem_req & ~mem_ack, stallreq_ex, stallreq_id, if_req & ~if_ack);
    // A branch held in a stalled EX re-presents next cycle, so flush only when EX moves
    assign flush = branch_flag_i & (stall[3] == NoStop);

    assign ram_req   = r_ram_req;
    assign ram_we    = r_ram_we;
    assign ram_sel   = r_ram_sel;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;

    // Sequencing FSM: grant the RAM port, hold the request stable, release on completion
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_state     <= ST_IDLE;
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_sel   <= 4'b0000;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_drop      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_drop <= 1'b0;
                    if (mem_req) begin
                        // Data access belongs to the older instruction, so it wins
                        r_state     <= ST_MEM_WAIT;
                        r_ram_req   <= 1'b1;
                        r_ram_we    <= mem_we;
                        r_ram_sel   <= mem_sel;
                        r_ram_addr  <= mem_addr;
                        r_ram_wdata <= mem_wdata;
                    end else if (if_req && !branch_flag_i) begin
                        r_state     <= ST_IF_WAIT;
                        r_ram_req   <= 1'b1;
                        r_ram_we    <= 1'b0;
                        r_ram_sel   <= SEL_WORD;
                        r_ram_addr  <= if_addr;
                        r_ram_wdata <= '0;
                    end else begin
                        r_ram_req   <= 1'b0;
                    end
                end
                ST_IF_WAIT: begin
                    if (w_done) begin
                        r_state   <= ST_IDLE;
                        r_ram_req <= 1'b0;
                        r_drop    <= 1'b0;
                    end else if (branch_flag_i) begin
                        // Fetch in flight is wrong-path: let it finish but never ack it
                        r_drop    <= 1'b1;
                    end else begin
                        r_drop    <= r_drop;
                    end
                end
                ST_MEM_WAIT: begin
                    if (w_done) begin
                        r_state   <= ST_IDLE;
                        r_ram_req <= 1'b0;
                    end else begin
                        r_ram_req <= 1'b1;
                    end
                    r_drop <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_ram_req <= 1'b0;
                    r_drop    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the controller's rules.
module tb_pipe_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stallreq_id = 1'b0, stallreq_ex = 1'b0, branch_flag_i = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          mem_req = 1'b0, mem_we = 1'b0;
    logic [3:0]    mem_sel = 4'h0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          ram_req, ram_we;
    logic [3:0]    ram_sel;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_ack = 1'b0;
    logic [DW-1:0] ram_rdata = '0;
    logic [5:0]    stall;
    logic          flush, err_o;

    always #5 clk = ~clk;

    pipe_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .branch_flag_i(branch_flag_i),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ram_req(ram_req), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
        .stall(stall), .flush(flush), .err_o(err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One outstanding RAM transaction at most: who owns it, what was latched,
    // how many unacknowledged cycles it has waited, and whether it was killed.
    bit          m_busy = 1'b0, m_is_mem = 1'b0, m_drop = 1'b0;
    int          m_age  = 0;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_addr, m_wdata;

    bit          e_exp, e_done, e_mack, e_iack, e_flush;
    logic [31:0] e_rd;
    logic [5:0]  e_stall;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 1'b0;
            m_drop = 1'b0;
            m_age  = 0;
        end
        e_exp  = m_busy && (TO > 0) && !ram_ack && (m_age + 1 == TO);
        e_done = m_busy && (ram_ack || e_exp);
        e_mack = e_done && m_is_mem;
        e_iack = e_done && !m_is_mem && !m_drop;
        e_rd   = e_exp ? 32'h0 : ram_rdata;
        if (mem_req && !e_mack)      e_stall = 6'b011111;
        else if (stallreq_ex)        e_stall = 6'b001111;
        else if (stallreq_id)        e_stall = 6'b000111;
        else if (if_req && !e_iack)  e_stall = 6'b000011;
        else                         e_stall = 6'b000000;
        e_flush = branch_flag_i && !e_stall[3];

        check("m_ram_req",   ram_req,   m_busy);
        check("m_if_ack",    if_ack,    e_iack);
        check("m_mem_ack",   mem_ack,   e_mack);
        check("m_if_rdata",  if_rdata,  e_rd);
        check("m_mem_rdata", mem_rdata, e_rd);
        check("m_err",       err_o,     e_exp);
        check("m_stall",     stall,     e_stall);
        check("m_flush",     flush,     e_flush);
        if (m_busy) begin
            check("m_ram_we",   ram_we,   m_we);
            check("m_ram_sel",  ram_sel,  m_sel);
            check("m_ram_addr", ram_addr, m_addr);
            if (m_is_mem) check("m_ram_wdata", ram_wdata, m_wdata);
        end

        // advance to the state seen after the next rising edge
        if (rst) begin
            if (m_busy) begin
                if (e_done) begin
                    m_busy = 1'b0; m_drop = 1'b0; m_age = 0;
                end else begin
                    m_age++;
                    if (!m_is_mem && branch_flag_i) m_drop = 1'b1;
                end
            end else if (mem_req) begin
                m_busy = 1'b1; m_is_mem = 1'b1; m_drop = 1'b0; m_age = 0;
                m_we = mem_we; m_sel = mem_sel; m_addr = mem_addr; m_wdata = mem_wdata;
            end else if (if_req && !branch_flag_i) begin
                m_busy = 1'b1; m_is_mem = 1'b0; m_drop = 1'b0; m_age = 0;
                m_we = 1'b0; m_sel = 4'hF; m_addr = if_addr;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stallreq_id = 1'b0; stallreq_ex = 1'b0; branch_flag_i = 1'b0;
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0;
        ram_ack = 1'b0;
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);
        check("rst_ram_req", ram_req, 1'b0);
        check("rst_stall",   stall,   6'b000000);
        check("rst_err",     err_o,   1'b0);
        check("rst_flush",   flush,   1'b0);
        @(posedge clk); #3 rst = 1'b1;

        // T1: simple fetch
        to_drive(); if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk); check("t1_stall_wait", stall, 6'b000011); check("t1_idle_req", ram_req, 1'b0);
        to_drive(); ram_ack = 1'b1; ram_rdata = 32'h13;
        @(negedge clk);
        check("t1_addr", ram_addr, 32'h100); check("t1_sel", ram_sel, 4'hF);
        check("t1_if_ack", if_ack, 1'b1); check("t1_rdata", if_rdata, 32'h13);
        check("t1_stall_done", stall, 6'b000000);
        to_drive(); clear_inputs();
        @(negedge clk); check("t1_release", ram_req, 1'b0);

        // T2: MEM beats IF
        to_drive(); if_req = 1'b1; if_addr = 32'h200;
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'hF; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF;
        @(negedge clk); check("t2_stall_mem", stall, 6'b011111);
        to_drive();
        @(negedge clk);
        check("t2_we", ram_we, 1'b1); check("t2_addr", ram_addr, 32'h2000);
        check("t2_wdata", ram_wdata, 32'hDEADBEEF); check("t2_no_if_ack", if_ack, 1'b0);
        to_drive(); ram_ack = 1'b1; ram_rdata = 32'h0;
        @(negedge clk); check("t2_mem_ack", mem_ack, 1'b1); check("t2_stall_if", stall, 6'b000011);
        to_drive(); ram_ack = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk); check("t2_gap", ram_req, 1'b0);
        to_drive();
        @(negedge clk); check("t2_if_addr", ram_addr, 32'h200); check("t2_if_we", ram_we, 1'b0);
        to_drive(); ram_ack = 1'b1; ram_rdata = 32'h55;
        @(negedge clk); check("t2_if_ack", if_ack, 1'b1);
        to_drive(); clear_inputs();

        // T3: stall priority and flush gating
        to_drive(); stallreq_id = 1'b1; stallreq_ex = 1'b1; branch_flag_i = 1'b1;
        @(negedge clk); check("t3_stall_ex", stall, 6'b001111); check("t3_flush_held", flush, 1'b0);
        to_drive(); stallreq_ex = 1'b0;
        @(negedge clk); check("t3_stall_id", stall, 6'b000111); check("t3_flush", flush, 1'b1);
        to_drive(); clear_inputs();

        // T4: wrong-path fetch dropped
        to_drive(); if_req = 1'b1; if_addr = 32'h300;
        @(negedge clk); check("t4_stall", stall, 6'b000011);
        to_drive(); branch_flag_i = 1'b1;
        @(negedge clk); check("t4_flush", flush, 1'b1);
        to_drive(); branch_flag_i = 1'b0; if_addr = 32'h400; ram_ack = 1'b1; ram_rdata = 32'h99;
        @(negedge clk); check("t4_dropped", if_ack, 1'b0); check("t4_old_addr", ram_addr, 32'h300);
        to_drive(); ram_ack = 1'b0;
        @(negedge clk); check("t4_gap", ram_req, 1'b0);
        to_drive(); ram_ack = 1'b1; ram_rdata = 32'h77;
        @(negedge clk);
        check("t4_new_addr", ram_addr, 32'h400); check("t4_if_ack", if_ack, 1'b1);
        check("t4_rdata", if_rdata, 32'h77);
        to_drive(); clear_inputs();

        // T5: watchdog expiry on the 4th wait cycle
        to_drive(); mem_req = 1'b1; mem_sel = 4'h3; mem_addr = 32'h40; ram_rdata = 32'hAAAA5555;
        for (int w = 1; w <= 4; w++) begin
            to_drive();
            @(negedge clk);
            check("t5_err", err_o, (w == 4));
            check("t5_mem_ack", mem_ack, (w == 4));
            if (w == 4) check("t5_rdata", mem_rdata, 32'h0);
        end
        to_drive(); mem_req = 1'b0;
        @(negedge clk); check("t5_idle", ram_req, 1'b0); check("t5_err_once", err_o, 1'b0);

        // T6: reset mid transaction
        to_drive(); mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h500; mem_wdata = 32'h1234;
        to_drive();
        #2 rst = 1'b0;
        #1 check("t6_async_drop", ram_req, 1'b0);
        @(posedge clk); #3 mem_req = 1'b0; mem_we = 1'b0; ram_ack = 1'b1; rst = 1'b1;
        @(negedge clk); check("t6_no_ack", mem_ack, 1'b0); check("t6_no_req", ram_req, 1'b0);
        to_drive();
        @(negedge clk); check("t6_no_ack2", mem_ack, 1'b0);
        to_drive(); clear_inputs();

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            to_drive();
            mem_req       = ($urandom_range(0, 3) == 0);
            mem_we        = $urandom_range(0, 1) == 1;
            mem_sel       = 4'($urandom_range(0, 15));
            mem_addr      = $urandom;
            mem_wdata     = $urandom;
            if_req        = ($urandom_range(0, 9) < 6);
            if_addr       = $urandom;
            branch_flag_i = ($urandom_range(0, 6) == 0);
            stallreq_id   = ($urandom_range(0, 6) == 0);
            stallreq_ex   = ($urandom_range(0, 6) == 0);
            ram_ack       = ($urandom_range(0, 9) < 4);
            ram_rdata     = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b0;
                @(posedge clk); #3 rst = 1'b1;
            end
        end

        to_drive(); clear_inputs();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
